// File: rtl/cmd_pkg.sv
// Shared types and constants for the command processor.
// The optional watchdog is enabled with the TIMEOUT_EN macro.
package cmd_pkg;

  typedef enum logic [2:0] {
    OP_CAL = 3'b000,
    OP_HDG = 3'b001,
    OP_MOV = 3'b010,
    OP_SLV = 3'b011
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE,
    CAL_W,
    HDG_W,
    MOV_W,
    RESP
  } state_t;

  localparam logic [7:0]  ACK         = 8'hA5;
  localparam logic [7:0]  NAK         = 8'h5A;
  localparam int          TMO_W_DEF   = 24;
  localparam logic [23:0] TMO_CYC_DEF = 24'hFF_FFFF;

endpackage

// File: rtl/cmd_proc_resp_sender.sv
// Response byte holder and UART transmit handshake for cmd_proc.
// Owns tx_busy, the resp register and the one-cycle send_resp pulse.
module resp_sender
  import cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld_i,
  input  logic       nak_i,
  input  logic       req_i,
  input  logic       tx_done_i,
  output logic [7:0] resp_o,
  output logic       send_o
);

  logic       busy_q, busy_d;
  logic [7:0] resp_q, resp_d;

  assign send_o = req_i & ~busy_q;

  // A new send in the same cycle as tx_done keeps the UART marked busy.
  always_comb begin
    busy_d = busy_q;
    if (send_o)         busy_d = 1'b1;
    else if (tx_done_i) busy_d = 1'b0;
    resp_d = resp_q;
    if (ld_i) resp_d = nak_i ? NAK : ACK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      resp_q <= 8'h00;
    end else begin
      busy_q <= busy_d;
      resp_q <= resp_d;
    end
  end

  assign resp_o = resp_q;

endmodule

// File: rtl/cmd_proc.sv
// Command processor: decodes UART commands, launches navigation actions, returns ack/nak.
// Define TIMEOUT_EN to add a watchdog that aborts any WAIT state after TMO_CYC cycles.
module cmd_proc
  import cmd_pkg::*;
`ifdef TIMEOUT_EN
#(
  parameter int               TMO_W   = TMO_W_DEF,
  parameter logic [TMO_W-1:0] TMO_CYC = TMO_W'(TMO_CYC_DEF)
)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic [7:0]  resp,
  output logic        send_resp,
  input  logic        tx_done,
  output logic        strt_cal,
  input  logic        cal_done,
  output logic [11:0] dsrd_hdg,
  output logic        hdg_vld,
  input  logic        at_hdg,
  output logic        strt_mv,
  input  logic        mv_cmplt,
  output logic        strt_slv
);

  state_t      state_q, state_d;
  logic [11:0] hdg_q, hdg_d;
  logic        vld_q, vld_d;
  logic        ld_resp, ld_nak, resp_req, tmo_hit;
  logic        in_wait;
  logic        unused_cmd_bit;

  assign unused_cmd_bit = cmd[12];
  assign in_wait  = (state_q == CAL_W) || (state_q == HDG_W) || (state_q == MOV_W);
  assign resp_req = (state_q == RESP);

`ifdef TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Held at zero outside WAIT, so it starts from zero on every WAIT entry.
  always_comb tmo_d = in_wait ? tmo_q + TMO_W'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end

  assign tmo_hit = in_wait && (tmo_q == TMO_CYC - TMO_W'(1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    hdg_d       = hdg_q;
    vld_d       = vld_q;
    clr_cmd_rdy = 1'b0;
    strt_cal    = 1'b0;
    strt_mv     = 1'b0;
    strt_slv    = 1'b0;
    ld_resp     = 1'b0;
    ld_nak      = 1'b0;
    case (state_q)
      IDLE: if (cmd_rdy) begin
        clr_cmd_rdy = 1'b1;
        case (cmd[15:13])
          OP_CAL: begin strt_cal = 1'b1; state_d = CAL_W; end
          OP_HDG: begin
            hdg_d   = cmd[11:0];
            vld_d   = 1'b1;
            state_d = HDG_W;
          end
          OP_MOV: begin strt_mv = 1'b1; state_d = MOV_W; end
          OP_SLV: begin strt_slv = 1'b1; ld_resp = 1'b1; state_d = RESP; end
          default: begin ld_resp = 1'b1; ld_nak = 1'b1; state_d = RESP; end
        endcase
      end
      CAL_W, HDG_W, MOV_W: begin
        // Completion wins over a watchdog expiry in the same cycle.
        if ((state_q == CAL_W && cal_done) || (state_q == HDG_W && at_hdg) ||
            (state_q == MOV_W && mv_cmplt)) begin
          ld_resp = 1'b1;
          state_d = RESP;
        end else if (tmo_hit) begin
          ld_resp = 1'b1;
          ld_nak  = 1'b1;
          vld_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: if (send_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hdg_q   <= 12'h000;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hdg_q   <= hdg_d;
      vld_q   <= vld_d;
    end
  end

  assign dsrd_hdg = hdg_q;
  assign hdg_vld  = vld_q;

  resp_sender u_resp (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_i      (ld_resp),
    .nak_i     (ld_nak),
    .req_i     (resp_req),
    .tx_done_i (tx_done),
    .resp_o    (resp),
    .send_o    (send_resp)
  );

endmodule

// File: tb/tb_cmd_proc.sv
// Self-checking bench for cmd_proc: vector table, random commands, multi-cycle corner cases.
// Build with TIMEOUT_EN defined to also exercise the watchdog (TMO_CYC=100).
module tb_cmd_proc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd = 16'h0;
  logic        cmd_rdy = 1'b0, tx_done = 1'b0, cal_done = 1'b0, at_hdg = 1'b0, mv_cmplt = 1'b0;
  logic        clr_cmd_rdy, send_resp, strt_cal, hdg_vld, strt_mv, strt_slv;
  logic [7:0]  resp;
  logic [11:0] dsrd_hdg;

  always #5 clk = ~clk;

`ifdef TIMEOUT_EN
  cmd_proc #(.TMO_W(24), .TMO_CYC(24'd100)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .resp(resp), .send_resp(send_resp), .tx_done(tx_done), .strt_cal(strt_cal),
    .cal_done(cal_done), .dsrd_hdg(dsrd_hdg), .hdg_vld(hdg_vld), .at_hdg(at_hdg),
    .strt_mv(strt_mv), .mv_cmplt(mv_cmplt), .strt_slv(strt_slv)
  );
`else
  cmd_proc dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .resp(resp), .send_resp(send_resp), .tx_done(tx_done), .strt_cal(strt_cal),
    .cal_done(cal_done), .dsrd_hdg(dsrd_hdg), .hdg_vld(hdg_vld), .at_hdg(at_hdg),
    .strt_mv(strt_mv), .mv_cmplt(mv_cmplt), .strt_slv(strt_slv)
  );
`endif

  int errs = 0, checks = 0;
  int n_clr = 0, n_cal = 0, n_mv = 0, n_slv = 0, n_send = 0;
  logic [7:0] last_resp = 8'h00;
  bit hold_tx = 1'b0;
  // Reference model of the sticky heading outputs
  logic [11:0] m_hdg = 12'h000;
  logic        m_vld = 1'b0;

  always @(negedge clk) begin
    if (clr_cmd_rdy) n_clr++;
    if (strt_cal)    n_cal++;
    if (strt_mv)     n_mv++;
    if (strt_slv)    n_slv++;
    if (send_resp) begin n_send++; last_resp = resp; end
  end

  // UART model: finishes a byte 3 cycles after send_resp unless held.
  initial begin
    forever begin
      @(negedge clk);
      if (send_resp) begin
        repeat (3) @(posedge clk);
        while (hold_tx) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clr(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (clr_cmd_rdy) begin ok = 1'b1; break; end
    end
    chk({name, ".clr_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_send(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (send_resp) begin ok = 1'b1; break; end
    end
    chk({name, ".send_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic chk_idle_outs(input string name);
    chk({name, ".clr"},  32'(clr_cmd_rdy), 0);
    chk({name, ".send"}, 32'(send_resp), 0);
    chk({name, ".strt"}, {29'd0, strt_cal, strt_mv, strt_slv}, 0);
    chk({name, ".resp"}, 32'(resp), 0);
    chk({name, ".hdg"},  32'(dsrd_hdg), 0);
    chk({name, ".vld"},  32'(hdg_vld), 0);
  endtask

  // Full command transaction; completion arrives dly cycles into the WAIT state.
  task automatic run_cmd(input logic [15:0] c, input int dly, input logic [7:0] e_resp,
                         input int e_cal, input int e_mv, input int e_slv, input string name);
    int c_clr = n_clr, c_cal = n_cal, c_mv = n_mv, c_slv = n_slv, c_send = n_send;
    cmd = c; cmd_rdy = 1'b1;
    wait_clr(name);
    step();
    cmd_rdy = 1'b0;
    if (c[15:13] == 3'd1) begin m_hdg = c[11:0]; m_vld = 1'b1; end
    case (c[15:13])
      3'd0: begin repeat (dly) step(); cal_done = 1'b1; step(); cal_done = 1'b0; end
      3'd1: begin repeat (dly) step(); at_hdg = 1'b1; end
      3'd2: begin repeat (dly) step(); mv_cmplt = 1'b1; step(); mv_cmplt = 1'b0; end
      default: ;
    endcase
    wait_send(name);
    step();
    at_hdg = 1'b0;
    chk({name, ".resp"}, 32'(last_resp), 32'(e_resp));
    chk({name, ".nclr"}, n_clr - c_clr, 1);
    chk({name, ".ncal"}, n_cal - c_cal, e_cal);
    chk({name, ".nmv"},  n_mv - c_mv, e_mv);
    chk({name, ".nslv"}, n_slv - c_slv, e_slv);
    chk({name, ".nsend"}, n_send - c_send, 1);
    chk({name, ".hdg"}, 32'(dsrd_hdg), 32'(m_hdg));
    chk({name, ".vld"}, 32'(hdg_vld), 32'(m_vld));
  endtask

  typedef struct {
    logic [15:0] c;
    int          dly;
    logic [7:0]  resp;
    int          cal, mv, slv;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int c_clr, c_cal, c_slv, c_send;
    tbl[0] = '{16'h0000, 50, 8'hA5, 1, 0, 0};
    tbl[1] = '{16'h2123, 20, 8'hA5, 0, 0, 0};
    tbl[2] = '{16'hE000,  0, 8'h5A, 0, 0, 0};
    tbl[3] = '{16'h4000,  3, 8'hA5, 0, 1, 0};
    tbl[4] = '{16'h6000,  0, 8'hA5, 0, 0, 1};
    tbl[5] = '{16'h8FFF,  0, 8'h5A, 0, 0, 0};
    tbl[6] = '{16'h3FFF,  0, 8'hA5, 0, 0, 0};

    repeat (3) step();
    chk_idle_outs("reset");
    rst_n = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 7; i++)
      run_cmd(tbl[i].c, tbl[i].dly, tbl[i].resp, tbl[i].cal, tbl[i].mv, tbl[i].slv,
              $sformatf("vec%0d", i));

    // Random commands checked against opcode rules
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op = 3'($urandom_range(0, 7));
      logic [15:0] c  = {op, 13'($urandom)};
      run_cmd(c, $urandom_range(0, 30), (op < 3'd4) ? 8'hA5 : 8'h5A,
              int'(op == 3'd0), int'(op == 3'd2), int'(op == 3'd3), $sformatf("rnd%0d", i));
    end

    // Completion inputs in IDLE are ignored
    repeat (10) step();
    c_send = n_send; c_clr = n_clr;
    cal_done = 1'b1; mv_cmplt = 1'b1; at_hdg = 1'b1;
    step();
    cal_done = 1'b0; mv_cmplt = 1'b0; at_hdg = 1'b0;
    repeat (10) step();
    chk("idle_ign.send", n_send - c_send, 0);
    chk("idle_ign.clr", n_clr - c_clr, 0);

    // SLV while the UART is still busy with a NAK
    hold_tx = 1'b1;
    run_cmd(16'hE000, 0, 8'h5A, 0, 0, 0, "busy_nak");
    c_send = n_send; c_slv = n_slv;
    cmd = 16'h6000; cmd_rdy = 1'b1;
    wait_clr("busy_slv");
    step();
    cmd_rdy = 1'b0;
    repeat (10) step();
    chk("busy_slv.nslv", n_slv - c_slv, 1);
    chk("busy_slv.held", n_send - c_send, 0);
    hold_tx = 1'b0;
    wait_send("busy_slv");
    step();
    chk("busy_slv.resp", 32'(last_resp), 32'hA5);
    chk("busy_slv.nsend", n_send - c_send, 1);

    // Second command pending during MOV_W waits for the move to finish
    cmd = 16'h4000; cmd_rdy = 1'b1;
    wait_clr("pend_mv");
    step();
    c_clr = n_clr; c_cal = n_cal;
    cmd = 16'h0000;
    repeat (10) step();
    chk("pend.noclr", n_clr - c_clr, 0);
    mv_cmplt = 1'b1; step(); mv_cmplt = 1'b0;
    wait_send("pend_mv");
    wait_clr("pend_cal");
    step();
    cmd_rdy = 1'b0;
    chk("pend.resp_mv", 32'(last_resp), 32'hA5);
    chk("pend.ncal", n_cal - c_cal, 1);
    cal_done = 1'b1; step(); cal_done = 1'b0;
    wait_send("pend_cal");
    step();
    chk("pend.resp_cal", 32'(last_resp), 32'hA5);

    // Reset during CAL_W, with hdg_vld set from an earlier heading
    run_cmd(16'h2456, 2, 8'hA5, 0, 0, 0, "pre_rst");
    repeat (6) step();
    cmd = 16'h0000; cmd_rdy = 1'b1;
    wait_clr("rst_mid");
    step();
    cmd_rdy = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    chk_idle_outs("rst_mid");
    m_hdg = 12'h000; m_vld = 1'b0;
    step();
    rst_n = 1'b1;
    c_send = n_send;
    cal_done = 1'b1; step(); cal_done = 1'b0;
    repeat (20) step();
    chk("rst_mid.nosend", n_send - c_send, 0);

`ifdef TIMEOUT_EN
    begin
      int k = 0;
      cmd = 16'h4000; cmd_rdy = 1'b1;
      wait_clr("tmo_mv");
      step();
      cmd_rdy = 1'b0;
      for (int i = 1; i <= 300; i++) begin
        @(negedge clk);
        if (send_resp) begin k = i; break; end
      end
      chk("tmo_mv.cycle", k, 101);
      step();
      chk("tmo_mv.resp", 32'(last_resp), 32'h5A);
      c_send = n_send;
      mv_cmplt = 1'b1; step(); mv_cmplt = 1'b0;
      repeat (10) step();
      chk("tmo_mv.late", n_send - c_send, 0);
      cmd = 16'h2055; cmd_rdy = 1'b1;
      wait_clr("tmo_hdg");
      step();
      cmd_rdy = 1'b0;
      wait_send("tmo_hdg");
      step();
      chk("tmo_hdg.resp", 32'(last_resp), 32'h5A);
      chk("tmo_hdg.vld", 32'(hdg_vld), 0);
      repeat (6) step();
      cmd = 16'h4000; cmd_rdy = 1'b1;
      wait_clr("tmo_rst");
      step();
      cmd_rdy = 1'b0;
      repeat (30) step();
      rst_n = 1'b0;
      #1;
      chk_idle_outs("tmo_rst");
      step();
      rst_n = 1'b1;
    end
`endif

    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
